// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART transmitter:
// FSM state encoding, parity mode codes and the default bit divider.
package uart_pkg;

   // 27 MHz system clock / 115200 baud
   localparam int unsigned DEF_CLK_DIV = 234;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with show-ahead read data.
// Ports: push/wdata write, pop advances rdata, full/empty/count status.
module uart_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // DEPTH is a power of two, so pointers wrap by overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // storage needs no reset; empty/count guard stale entries
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: FIFO-buffered words, serialised as
// start, data LSB first, optional parity, stop. Ports: TX_DATA/TX_VALID/
// TX_READY push side, TX_OUT line, TX_BUSY and FIFO_COUNT status.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = PAR_NONE,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          SYS_CLK,
   input  logic                          RST_N,
   input  logic [DATA_BITS-1:0]          TX_DATA,
   input  logic                          TX_VALID,
   output logic                          TX_READY,
   output logic                          TX_OUT,
   output logic                          TX_BUSY,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

   if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_div
      $fatal(1, "uart_tx_param: CLK_DIV out of range");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
      $fatal(1, "uart_tx_param: DATA_BITS out of range");
   end
   if (PARITY > PAR_EVEN) begin : g_bad_par
      $fatal(1, "uart_tx_param: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $fatal(1, "uart_tx_param: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "uart_tx_param: FIFO_DEPTH must be a power of two in 2..64");
   end

   localparam logic PAR_INV = (PARITY == PAR_ODD);

   tx_state_t            state;
   logic [15:0]          baud_cnt;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 tx_q;
   logic [DATA_BITS-1:0] fifo_rdata;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 bit_end;
   logic                 last_stop;
   logic                 pop;
   logic                 line;

   uart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (SYS_CLK),
      .rst_n (RST_N),
      .push  (TX_VALID),
      .wdata (TX_DATA),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (FIFO_COUNT)
   );

   assign bit_end   = (baud_cnt == 16'(CLK_DIV - 1));
   assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));

   // next word is taken when idle, or right as the final stop bit ends
   assign pop = !fifo_empty &&
                ((state == IDLE) ||
                 (state == STOP && bit_end && last_stop));

   always_comb begin
      line = 1'b1;
      unique case (state)
         START:   line = 1'b0;
         DATA:    line = shreg[0];
         PAR:     line = par_bit;
         default: line = 1'b1;
      endcase
   end

   always_ff @(posedge SYS_CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         tx_q <= line;
         if (state == IDLE || bit_end) baud_cnt <= '0;
         else                          baud_cnt <= baud_cnt + 1'b1;
         if (pop) begin
            state   <= START;
            bit_cnt <= '0;
            shreg   <= fifo_rdata;
            par_bit <= (^fifo_rdata) ^ PAR_INV;
         end else if (bit_end) begin
            unique case (state)
               START: begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
               DATA: begin
                  shreg <= shreg >> 1;
                  if (bit_cnt == 4'(DATA_BITS - 1)) begin
                     bit_cnt <= '0;
                     state   <= (PARITY == PAR_NONE) ? STOP : PAR;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               PAR: begin
                  state   <= STOP;
                  bit_cnt <= '0;
               end
               STOP: begin
                  if (last_stop) state   <= IDLE;
                  else           bit_cnt <= bit_cnt + 1'b1;
               end
               default: state <= state;
            endcase
         end
      end
   end

   assign TX_OUT   = tx_q;
   assign TX_BUSY  = (state != IDLE) || !fifo_empty;
   assign TX_READY = !fifo_full;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: frame format, parity, stop bits,
// backpressure, simultaneous push/pop and asynchronous reset.
module tb_uart_tx_param;

   logic       clk;
   logic       rst0;
   logic       rstc;
   logic [3:0] vld;
   logic [7:0] d0;
   logic [7:0] d1;
   logic [7:0] d2;
   logic [6:0] d3;
   wire  [3:0] txv;
   wire  [3:0] busyv;
   wire  [3:0] rdyv;
   wire  [2:0] cnt0;
   wire  [2:0] cnt1;
   wire  [2:0] cnt2;
   wire  [2:0] cnt3;

   int n_chk;
   int n_err;

   uart_tx_param #(.CLK_DIV(4)) u0 (
      .SYS_CLK(clk), .RST_N(rst0), .TX_DATA(d0), .TX_VALID(vld[0]),
      .TX_READY(rdyv[0]), .TX_OUT(txv[0]), .TX_BUSY(busyv[0]),
      .FIFO_COUNT(cnt0));

   uart_tx_param #(.CLK_DIV(4), .PARITY(2)) u1 (
      .SYS_CLK(clk), .RST_N(rstc), .TX_DATA(d1), .TX_VALID(vld[1]),
      .TX_READY(rdyv[1]), .TX_OUT(txv[1]), .TX_BUSY(busyv[1]),
      .FIFO_COUNT(cnt1));

   uart_tx_param #(.CLK_DIV(4), .PARITY(1)) u2 (
      .SYS_CLK(clk), .RST_N(rstc), .TX_DATA(d2), .TX_VALID(vld[2]),
      .TX_READY(rdyv[2]), .TX_OUT(txv[2]), .TX_BUSY(busyv[2]),
      .FIFO_COUNT(cnt2));

   uart_tx_param #(.CLK_DIV(4), .DATA_BITS(7), .STOP_BITS(2)) u3 (
      .SYS_CLK(clk), .RST_N(rstc), .TX_DATA(d3), .TX_VALID(vld[3]),
      .TX_READY(rdyv[3]), .TX_OUT(txv[3]), .TX_BUSY(busyv[3]),
      .FIFO_COUNT(cnt3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // bit time i of a frame becomes cycles 4i..4i+3
   function automatic logic [63:0] expand(input logic [15:0] b,
                                          input int nb);
      logic [63:0] w;
      w = '0;
      for (int i = 0; i < nb * 4; i++) w[i] = b[i / 4];
      return w;
   endfunction

   task automatic drive(input int idx, input logic v, input logic [7:0] d);
      vld[idx] = v;
      case (idx)
         0: d0 = d;
         1: d1 = d;
         2: d2 = d;
         default: d3 = d[6:0];
      endcase
   endtask

   // push one word into an idle DUT and capture its whole frame
   task automatic frame(input int idx, input logic [7:0] d,
                        input logic [15:0] bits, input int nb,
                        input string tag);
      logic [63:0] w;
      logic [63:0] bw;
      int          len;
      len = nb * 4;
      w   = '0;
      bw  = '0;
      drive(idx, 1'b1, d);
      @(negedge clk);
      drive(idx, 1'b0, 8'hFF);
      chk({tag, "_lat1"}, 64'(txv[idx]), 64'd1);
      @(negedge clk);
      chk({tag, "_lat2"}, 64'(txv[idx]), 64'd1);
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         w[i]  = txv[idx];
         bw[i] = busyv[idx];
      end
      chk({tag, "_wave"}, w, expand(bits, nb));
      chk({tag, "_busy_end"}, 64'(bw[len-2]), 64'd1);
      chk({tag, "_busy_off"}, 64'(bw[len-1]), 64'd0);
      @(negedge clk);
      chk({tag, "_idle"}, 64'(txv[idx]), 64'd1);
   endtask

   task automatic backpressure();
      logic [7:0] wd [6];
      logic       rec [260];
      logic [63:0] got;
      int acc;
      int low_bad;
      acc     = 0;
      low_bad = 0;
      wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;
      wd[3] = 8'h44; wd[4] = 8'h5A; wd[5] = 8'hC3;
      for (int k = 0; k < 260; k++) begin
         @(negedge clk);
         rec[k] = txv[0];
         if (k == 5)  chk("bp_full_cnt", 64'(cnt0), 64'd4);
         if (k >= 5 && k <= 41 && rdyv[0]) low_bad++;
         if (k == 41) chk("bp_acc5", 64'(acc), 64'd5);
         if (k == 42) chk("bp_rdy_back", 64'(rdyv[0]), 64'd1);
         if (acc < 6) begin
            drive(0, 1'b1, wd[acc]);
            if (rdyv[0]) acc++;
         end else begin
            drive(0, 1'b0, 8'h00);
         end
      end
      chk("bp_rdy_low", 64'(low_bad), 64'd0);
      for (int j = 0; j < 6; j++) begin
         got = '0;
         for (int i = 0; i < 40; i++) got[i] = rec[3 + 40 * j + i];
         chk($sformatf("bp_frame%0d", j), got,
             expand({1'b1, wd[j], 1'b0}, 10));
      end
      chk("bp_after", 64'(rec[243]), 64'd1);
      chk("bp_busy_end", 64'(busyv[0]), 64'd0);
   endtask

   task automatic pushpop();
      for (int k = 0; k < 170; k++) begin
         @(negedge clk);
         if (k == 41) chk("pp_cnt_before", 64'(cnt0), 64'd2);
         if (k == 42) chk("pp_cnt_after", 64'(cnt0), 64'd2);
         if (k < 3)        drive(0, 1'b1, 8'hA0 + 8'(k));
         else if (k == 41) drive(0, rdyv[0], 8'hA3);
         else              drive(0, 1'b0, 8'h00);
      end
      chk("pp_drained", 64'(busyv[0]), 64'd0);
   endtask

   task automatic reset_mid();
      int bad;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         drive(0, (k < 3), 8'h00);
      end
      @(negedge clk);
      chk("rm_pre_tx", 64'(txv[0]), 64'd0);
      chk("rm_pre_cnt", 64'(cnt0), 64'd2);
      rst0 = 1'b0;
      #1;
      chk("rm_tx", 64'(txv[0]), 64'd1);
      chk("rm_cnt", 64'(cnt0), 64'd0);
      chk("rm_rdy", 64'(rdyv[0]), 64'd1);
      chk("rm_busy", 64'(busyv[0]), 64'd0);
      drive(0, 1'b1, 8'h5A);
      repeat (3) @(negedge clk);
      chk("rm_push_ign", 64'(cnt0), 64'd0);
      drive(0, 1'b0, 8'h00);
      rst0 = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (txv[0] !== 1'b1 || busyv[0] !== 1'b0) bad++;
      end
      chk("rm_quiet", 64'(bad), 64'd0);
      rst0 = 1'b0;
      drive(0, 1'b1, 8'h3C);
      @(negedge clk);
      rst0 = 1'b1;
      @(negedge clk);
      drive(0, 1'b0, 8'h00);
      chk("rm_first_push", 64'(cnt0), 64'd1);
      chk("rm_first_busy", 64'(busyv[0]), 64'd1);
      repeat (60) @(negedge clk);
      chk("rm_final_idle", 64'(busyv[0]), 64'd0);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst0  = 1'b0;
      rstc  = 1'b0;
      vld   = '0;
      d0 = '0; d1 = '0; d2 = '0; d3 = '0;
      repeat (2) @(negedge clk);
      chk("rst_tx", 64'(txv), 64'hF);
      chk("rst_rdy", 64'(rdyv), 64'hF);
      chk("rst_busy", 64'(busyv), 64'h0);
      chk("rst_cnt", 64'({cnt3, cnt2, cnt1, cnt0}), 64'h0);
      rst0 = 1'b1;
      rstc = 1'b1;
      @(negedge clk);
      frame(0, 8'h55, 16'({1'b1, 8'h55, 1'b0}), 10, "f8n1");
      frame(1, 8'h07, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, "feven");
      frame(2, 8'h07, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, "fodd");
      frame(3, 8'h7F, 16'({2'b11, 7'h7F, 1'b0}), 10, "f7n2");
      backpressure();
      pushpop();
      reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
